res_gen: RTL

Four-resolution stimulus generator and resolution selector, the source end of the per-resolution output mux. It produces four pulse/reference channel pairs, one per resolution. Channel k runs at twice the period of channel k-1. It also debounces the front-panel button and drives the 2-bit resolution `state` that selects among the channels downstream. On every accepted press, the shared phase counter restarts so the newly selected channel begins at phase 0.

---
 rtl/res_gen_if.sv | 36 +++
 rtl/res_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/res_gen_if.sv
// Button/enable inputs and per-resolution channel outputs of res_gen.
// master: the generator side (res_gen); slave: the consumer/mux side.
//   b1            raw asynchronous push-button, active high
//   en            generator run enable
//   pd_out0..3    one-cycle pulse per channel period
//   com_out0..3   50% duty reference square wave per channel
//   state         current resolution select
//   sel_chg       one-cycle strobe when state changes
interface res_gen_if;
    logic       b1;
    logic       en;
    logic       pd_out0;
    logic       pd_out1;
    logic       pd_out2;
    logic       pd_out3;
    logic       com_out0;
    logic       com_out1;
    logic       com_out2;
    logic       com_out3;
    logic [1:0] state;
    logic       sel_chg;

    modport master (
        input  b1, en,
        output pd_out0, pd_out1, pd_out2, pd_out3,
        output com_out0, com_out1, com_out2, com_out3,
        output state, sel_chg
    );

    modport slave (
        output b1, en,
        input  pd_out0, pd_out1, pd_out2, pd_out3,
        input  com_out0, com_out1, com_out2, com_out3,
        input  state, sel_chg
    );
endinterface

// File: rtl/res_gen.sv
// Four-resolution stimulus generator with debounced resolution selector.
// Channel k has period 2^(BASE_LOG2+k); a debounced button press advances
// the 2-bit resolution select and restarts the shared phase counter.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    res_gen_if.master (b1, en in; pd/com channels, state, sel_chg out)
module res_gen #(
    parameter int unsigned BASE_LOG2  = 4,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    res_gen_if.master   bus
);
    localparam int unsigned CW = BASE_LOG2 + 3;
    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          b_m;
    logic          b_s;
    logic          b_stable;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    state_q;
    logic          sel_chg_q;
    logic [3:0]    pd_q;
    logic [3:0]    com_q;
    logic          differ_c;
    logic          press_c;

    // A press is the debounced 0->1 acceptance of the synchronized button.
    assign differ_c = b_s ^ b_stable;
    assign press_c  = differ_c & b_s & (deb_cnt == DEB_LAST);

    // Two-flop synchronizer and debounce counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_m      <= 1'b0;
            b_s      <= 1'b0;
            b_stable <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            b_m <= bus.b1;
            b_s <= b_m;
            if (!differ_c) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                b_stable <= b_s;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Resolution select and its change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= 2'b00;
            sel_chg_q <= 1'b0;
        end else begin
            sel_chg_q <= press_c;
            if (press_c) begin
                state_q <= state_q + 2'd1;
            end
        end
    end

    // Shared phase counter; a press restarts it regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (press_c) begin
            cnt <= '0;
        end else if (bus.en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Per-channel pulse and reference, decoded from the low phase bits.
    for (genvar k = 0; k < 4; k++) begin : g_ch
        localparam int unsigned LW = BASE_LOG2 + k;
        logic pd_r;
        logic com_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pd_r  <= 1'b0;
                com_r <= 1'b0;
            end else begin
                pd_r  <= (cnt[LW-1:0] == '0) & bus.en;
                com_r <= ~cnt[LW-1];
            end
        end

        assign pd_q[k]  = pd_r;
        assign com_q[k] = com_r;
    end

    assign bus.pd_out0  = pd_q[0];
    assign bus.pd_out1  = pd_q[1];
    assign bus.pd_out2  = pd_q[2];
    assign bus.pd_out3  = pd_q[3];
    assign bus.com_out0 = com_q[0];
    assign bus.com_out1 = com_q[1];
    assign bus.com_out2 = com_q[2];
    assign bus.com_out3 = com_q[3];
    assign bus.state    = state_q;
    assign bus.sel_chg  = sel_chg_q;
endmodule
